// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer for the EX stage: 16-step shift-add multiply
// and restoring divide, with a pipeline stall. The divider is built only when MULDIV_DIV_EN is defined.
module muldiv_sequencer #(
  parameter logic [3:0] OP_MUL = 4'b0100,
  parameter logic [3:0] OP_DIV = 4'b0101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [15:0] res_lo,
  output logic [15:0] res_hi,
  output logic        wr_en,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_next;
  logic        is_mul, valid_op, accept;
  logic [3:0]  count;
  logic [15:0] opnd;
  logic [31:0] acc;
  logic        neg_res;
  logic [16:0] mul_sum;
  logic [31:0] mul_next;
  logic [31:0] prod_fix;

  function automatic logic [15:0] mag(input logic [15:0] x);
    return x[15] ? 16'(-x) : x;
  endfunction

  assign is_mul = (op == OP_MUL);

`ifdef MULDIV_DIV_EN
  logic        is_div, dbz_accept, op_div, neg_rem, dbz_q;
  logic [17:0] div_diff;
  logic [31:0] div_next;
  logic [15:0] quo_fix, rem_fix;

  assign is_div     = (op == OP_DIV);
  assign valid_op   = is_mul | is_div;
  assign dbz_accept = accept & is_div & (op2 == 16'h0000);

  // acc holds {remainder, quotient}; the quotient bits shift in from the bottom
  // as the dividend bits shift out of the top.
  assign div_diff = {1'b0, acc[31:15]} - {2'b00, opnd};
  assign div_next = div_diff[17] ? {acc[30:0], 1'b0}
                                 : {div_diff[15:0], acc[14:0], 1'b1};
  assign quo_fix  = neg_res ? 16'(-acc[15:0])  : acc[15:0];
  assign rem_fix  = neg_rem ? 16'(-acc[31:16]) : acc[31:16];
  assign div_by_zero = done & dbz_q;
`else
  assign valid_op    = is_mul;
  assign div_by_zero = 1'b0;
`endif

  assign accept = (state == IDLE) & start & valid_op & ~rst;

  // acc holds {partial product, remaining multiplier bits}; one multiplier bit retires per step.
  assign mul_sum  = {1'b0, acc[31:16]} + {1'b0, (acc[0] ? opnd : 16'h0000)};
  assign mul_next = {mul_sum, acc[15:1]};
  assign prod_fix = neg_res ? -acc : acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          state_next = CALC;
`ifdef MULDIV_DIV_EN
          if (dbz_accept) state_next = DONE;
`endif
        end
      end
      CALC: begin
        stall = 1'b1;
        if (count == 4'd15) state_next = FIX;
      end
      FIX: begin
        stall      = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign wr_en = done;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 4'd0;
      opnd    <= 16'h0000;
      acc     <= 32'h0;
      neg_res <= 1'b0;
      res_lo  <= 16'h0000;
      res_hi  <= 16'h0000;
`ifdef MULDIV_DIV_EN
      op_div  <= 1'b0;
      neg_rem <= 1'b0;
      dbz_q   <= 1'b0;
`endif
    end else if (accept) begin
      count   <= 4'd0;
      neg_res <= op1[15] ^ op2[15];
      opnd    <= mag(op1);
      acc     <= {16'h0000, mag(op2)};
`ifdef MULDIV_DIV_EN
      op_div  <= is_div;
      neg_rem <= op1[15];
      dbz_q   <= dbz_accept;
      if (is_div) begin
        opnd <= mag(op2);
        acc  <= {16'h0000, mag(op1)};
      end
      // Divide by zero skips the datapath and publishes its fixed result at once.
      if (dbz_accept) begin
        res_lo <= 16'hFFFF;
        res_hi <= op1;
      end
`endif
    end else if (state == CALC) begin
      count <= count + 4'd1;
      acc   <= mul_next;
`ifdef MULDIV_DIV_EN
      if (op_div) acc <= div_next;
`endif
    end else if (state == FIX) begin
      res_lo <= prod_fix[15:0];
      res_hi <= prod_fix[31:16];
`ifdef MULDIV_DIV_EN
      if (op_div) begin
        res_lo <= quo_fix;
        res_hi <= rem_fix;
      end
`endif
    end
  end

endmodule
